// File: rtl/lsu_pkg.sv
// Shared encodings for the load/store unit: access sizes, FSM states and the
// byte-lane enable helper used by the store merge path.
package lsu_pkg;

   localparam logic [1:0] SZ_BYTE = 2'b00;
   localparam logic [1:0] SZ_HALF = 2'b01;
   localparam logic [1:0] SZ_WORD = 2'b10;
   localparam logic [1:0] SZ_ILL  = 2'b11;

   localparam logic [1:0] ST_IDLE  = 2'd0;
   localparam logic [1:0] ST_READ  = 2'd1;
   localparam logic [1:0] ST_WRITE = 2'd2;
   localparam logic [1:0] ST_RESP  = 2'd3;

   // Little-endian byte enables for an access of the given size at byte offset lo
   function automatic logic [3:0] lane_be(input logic [1:0] size, input logic [1:0] lo);
      logic [3:0] be;
      case (size)
         SZ_BYTE: be = 4'b0001 << lo;
         SZ_HALF: be = lo[1] ? 4'b1100 : 4'b0011;
         SZ_WORD: be = 4'b1111;
         default: be = 4'b0000;
      endcase
      return be;
   endfunction

endpackage

// File: rtl/lsu_lane_align.sv
// Combinational lane logic: load extraction with sign/zero extension, and
// sub-word merge of store data into the previously read word.
module lsu_lane_align
   import lsu_pkg::*;
(
   input  logic [1:0]  i_size,
   input  logic        i_signed,
   input  logic [1:0]  i_addr_lo,
   input  logic [31:0] i_rd_word,
   input  logic [31:0] i_rdbuf,
   input  logic [31:0] i_wdata,
   output logic [31:0] o_load_data,
   output logic [31:0] o_merged
);

   logic [7:0]  w_byte;
   logic [15:0] w_half;
   logic [31:0] w_wrep;
   logic [3:0]  w_be;

   // Select the addressed lane and extend it to a full word
   always_comb begin
      w_byte      = 8'h00;
      w_half      = 16'h0000;
      o_load_data = 32'h0000_0000;
      case (i_addr_lo)
         2'd0:    w_byte = i_rd_word[7:0];
         2'd1:    w_byte = i_rd_word[15:8];
         2'd2:    w_byte = i_rd_word[23:16];
         2'd3:    w_byte = i_rd_word[31:24];
         default: w_byte = 8'h00;
      endcase
      if (i_addr_lo[1]) begin
         w_half = i_rd_word[31:16];
      end else begin
         w_half = i_rd_word[15:0];
      end
      case (i_size)
         SZ_BYTE: o_load_data = {{24{i_signed & w_byte[7]}}, w_byte};
         SZ_HALF: o_load_data = {{16{i_signed & w_half[15]}}, w_half};
         default: o_load_data = i_rd_word;
      endcase
   end

   // Replicate store data across lanes, then keep only the enabled lanes
   always_comb begin
      w_be     = lane_be(i_size, i_addr_lo);
      w_wrep   = i_wdata;
      o_merged = i_rdbuf;
      case (i_size)
         SZ_BYTE: w_wrep = {4{i_wdata[7:0]}};
         SZ_HALF: w_wrep = {2{i_wdata[15:0]}};
         default: w_wrep = i_wdata;
      endcase
      for (int i = 0; i < 4; i++) begin
         if (w_be[i]) begin
            o_merged[8*i +: 8] = w_wrep[8*i +: 8];
         end else begin
            o_merged[8*i +: 8] = i_rdbuf[8*i +: 8];
         end
      end
   end

endmodule

// File: rtl/load_store_unit.sv
// Memory-access stage: one request at a time, byte/half/word loads and stores
// against a word-wide memory, with read-modify-write for sub-word stores.
module load_store_unit
   import lsu_pkg::*;
#(
   parameter int ADDR_W    = 32,
   parameter int DATA_W    = 32,
   parameter int MEM_WORDS = 100
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              req_valid,
   output logic              req_ready,
   input  logic              req_write,
   input  logic [1:0]        req_size,
   input  logic              req_signed,
   input  logic [ADDR_W-1:0] req_addr,
   input  logic [DATA_W-1:0] req_wdata,
   output logic              rsp_valid,
   output logic [DATA_W-1:0] rsp_rdata,
   output logic              rsp_fault,
   output logic [ADDR_W-1:0] mem_address,
   output logic [DATA_W-1:0] mem_dataIn,
   output logic              mem_writemode,
   output logic              mem_readmode,
   input  logic [DATA_W-1:0] mem_dataOut
);

   localparam logic [ADDR_W-3:0] L_MEM_WORDS = (ADDR_W-2)'(MEM_WORDS);

   logic [1:0]        r_state;
   logic              r_write;
   logic [1:0]        r_size;
   logic              r_signed;
   logic [ADDR_W-1:0] r_addr;
   logic [DATA_W-1:0] r_wdata;
   logic [DATA_W-1:0] r_rdbuf;
   logic              r_rsp_valid;
   logic [DATA_W-1:0] r_rsp_rdata;
   logic              r_rsp_fault;

   logic              w_fault;
   logic [DATA_W-1:0] w_load_data;
   logic [DATA_W-1:0] w_merged;

   lsu_lane_align u_lane (
      .i_size      (r_size),
      .i_signed    (r_signed),
      .i_addr_lo   (r_addr[1:0]),
      .i_rd_word   (mem_dataOut),
      .i_rdbuf     (r_rdbuf),
      .i_wdata     (r_wdata),
      .o_load_data (w_load_data),
      .o_merged    (w_merged)
   );

   // Fault is decided on the request being accepted, so it equals the latched check
   always_comb begin
      w_fault = 1'b0;
      if (req_size == SZ_ILL) begin
         w_fault = 1'b1;
      end else if ((req_size == SZ_HALF) && req_addr[0]) begin
         w_fault = 1'b1;
      end else if ((req_size == SZ_WORD) && (req_addr[1:0] != 2'b00)) begin
         w_fault = 1'b1;
      end else if (req_addr[ADDR_W-1:2] >= L_MEM_WORDS) begin
         w_fault = 1'b1;
      end else begin
         w_fault = 1'b0;
      end
   end

   // Strobes decode straight from state so an async reset drops them at once
   assign req_ready     = (r_state == ST_IDLE);
   assign mem_readmode  = (r_state == ST_READ);
   assign mem_writemode = (r_state == ST_WRITE);
   assign mem_dataIn    = mem_writemode ? w_merged : '0;
   assign mem_address   = {r_addr[ADDR_W-1:2], 2'b00};
   assign rsp_valid     = r_rsp_valid;
   assign rsp_rdata     = r_rsp_rdata;
   assign rsp_fault     = r_rsp_fault;

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         r_state     <= ST_IDLE;
         r_write     <= 1'b0;
         r_size      <= 2'b00;
         r_signed    <= 1'b0;
         r_addr      <= '0;
         r_wdata     <= '0;
         r_rdbuf     <= '0;
         r_rsp_valid <= 1'b0;
         r_rsp_rdata <= '0;
         r_rsp_fault <= 1'b0;
      end else begin
         r_rsp_valid <= 1'b0;
         case (r_state)
            ST_IDLE: begin
               r_rsp_rdata <= '0;
               r_rsp_fault <= 1'b0;
               if (req_valid) begin
                  r_write  <= req_write;
                  r_size   <= req_size;
                  r_signed <= req_signed;
                  r_addr   <= req_addr;
                  r_wdata  <= req_wdata;
                  if (w_fault) begin
                     r_rsp_valid <= 1'b1;
                     r_rsp_fault <= 1'b1;
                     r_state     <= ST_RESP;
                  end else if (!req_write || (req_size != SZ_WORD)) begin
                     r_state <= ST_READ;
                  end else begin
                     r_state <= ST_WRITE;
                  end
               end else begin
                  r_state <= ST_IDLE;
               end
            end
            ST_READ: begin
               r_rdbuf <= mem_dataOut;
               if (r_write) begin
                  r_state <= ST_WRITE;
               end else begin
                  r_rsp_rdata <= w_load_data;
                  r_rsp_valid <= 1'b1;
                  r_state     <= ST_RESP;
               end
            end
            ST_WRITE: begin
               r_rsp_valid <= 1'b1;
               r_state     <= ST_RESP;
            end
            ST_RESP: begin
               r_rsp_rdata <= '0;
               r_rsp_fault <= 1'b0;
               r_state     <= ST_IDLE;
            end
            default: r_state <= ST_IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_load_store_unit.sv
// Table-driven bench for load_store_unit with a behavioural word memory and a
// response scoreboard; plus hand sequences for reset-mid-write and back-to-back.
module tb_load_store_unit;

   typedef struct {
      logic        wr;
      logic [1:0]  sz;
      logic        sg;
      logic [31:0] addr;
      logic [31:0] wdata;
      logic [31:0] exp_rdata;
      logic        exp_fault;
      logic        chk_mem;
      logic [31:0] exp_mem;
   } vec_t;

   typedef struct {
      logic [31:0] rdata;
      logic        fault;
      int          lat;
   } exp_t;

   logic        clk = 1'b0;
   logic        rst;
   logic        req_valid, req_ready, req_write, req_signed;
   logic [1:0]  req_size;
   logic [31:0] req_addr, req_wdata;
   logic        rsp_valid, rsp_fault;
   logic [31:0] rsp_rdata;
   logic [31:0] mem_address, mem_dataIn, mem_dataOut;
   logic        mem_writemode, mem_readmode;

   logic [31:0] tb_mem [100] = '{default: 32'h0};
   logic [29:0] mem_idx;
   exp_t        sb_q [$];
   vec_t        vecs [20];
   vec_t        bb   [4];
   int          n_chk = 0;
   int          n_fail = 0;

   load_store_unit #(.ADDR_W(32), .DATA_W(32), .MEM_WORDS(100)) dut (
      .clk(clk), .rst(rst),
      .req_valid(req_valid), .req_ready(req_ready), .req_write(req_write),
      .req_size(req_size), .req_signed(req_signed), .req_addr(req_addr),
      .req_wdata(req_wdata), .rsp_valid(rsp_valid), .rsp_rdata(rsp_rdata),
      .rsp_fault(rsp_fault), .mem_address(mem_address), .mem_dataIn(mem_dataIn),
      .mem_writemode(mem_writemode), .mem_readmode(mem_readmode),
      .mem_dataOut(mem_dataOut)
   );

   always #5 clk = ~clk;

   assign mem_idx = mem_address[31:2];
   always_comb mem_dataOut = (mem_idx < 30'd100) ? tb_mem[mem_idx] : 32'h0;
   always @(posedge clk) if (mem_writemode && mem_idx < 30'd100) tb_mem[mem_idx] <= mem_dataIn;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_chk++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got 0x%08h, expected 0x%08h", name, act, exp);
      end
   endtask

   function automatic int exp_lat(input vec_t v);
      if (v.exp_fault) return 1;
      else if (!v.wr) return 2;
      else if (v.sz == 2'b10) return 2;
      else return 3;
   endfunction

   task automatic drive(input vec_t v);
      req_write  = v.wr;
      req_size   = v.sz;
      req_signed = v.sg;
      req_addr   = v.addr;
      req_wdata  = v.wdata;
   endtask

   task automatic run_vec(input int idx, input vec_t v);
      int   cyc;
      int   rdy_low;
      logic strobe;
      exp_t e;
      cyc = 0;
      while (!req_ready && cyc < 20) begin @(negedge clk); cyc++; end
      if (!req_ready) begin chk($sformatf("v%0d_ready_timeout", idx), 32'd0, 32'd1); return; end
      drive(v);
      req_valid = 1'b1;
      sb_q.push_back('{rdata: v.exp_rdata, fault: v.exp_fault, lat: exp_lat(v)});
      @(posedge clk);
      #1 req_valid = 1'b0;
      cyc = 0; rdy_low = 0; strobe = 1'b0;
      do begin
         @(negedge clk);
         cyc++;
         if (!req_ready) rdy_low++;
         if (mem_readmode || mem_writemode) strobe = 1'b1;
      end while (!rsp_valid && cyc < 20);
      e = sb_q.pop_front();
      if (!rsp_valid) begin chk($sformatf("v%0d_rsp_timeout", idx), 32'd0, 32'd1); return; end
      chk($sformatf("v%0d_rdata", idx), rsp_rdata, e.rdata);
      chk($sformatf("v%0d_fault", idx), {31'd0, rsp_fault}, {31'd0, e.fault});
      chk($sformatf("v%0d_latency", idx), cyc, e.lat);
      chk($sformatf("v%0d_ready_low", idx), rdy_low, e.lat);
      if (e.fault) chk($sformatf("v%0d_strobes", idx), {31'd0, strobe}, 32'd0);
      if (v.chk_mem) chk($sformatf("v%0d_mem", idx), tb_mem[v.addr[31:2]], v.exp_mem);
   endtask

   initial begin
      int   k, got, nacc;
      logic acc_pend, saw_rsp;
      exp_t e;

      //          wr    sz     sg    addr          wdata         exp_rdata     flt   chkm  exp_mem
      vecs[0]  = '{1'b1, 2'b10, 1'b0, 32'h0000_0010, 32'hDEAD_BEEF, 32'h0,        1'b0, 1'b1, 32'hDEAD_BEEF};
      vecs[1]  = '{1'b0, 2'b10, 1'b0, 32'h0000_0010, 32'h0,         32'hDEAD_BEEF, 1'b0, 1'b0, 32'h0};
      vecs[2]  = '{1'b1, 2'b00, 1'b0, 32'h0000_0011, 32'h0000_01A5, 32'h0,        1'b0, 1'b1, 32'hDEAD_A5EF};
      vecs[3]  = '{1'b0, 2'b00, 1'b1, 32'h0000_0011, 32'h0,         32'hFFFF_FFA5, 1'b0, 1'b0, 32'h0};
      vecs[4]  = '{1'b0, 2'b00, 1'b0, 32'h0000_0011, 32'h0,         32'h0000_00A5, 1'b0, 1'b0, 32'h0};
      vecs[5]  = '{1'b1, 2'b01, 1'b0, 32'h0000_0012, 32'h0000_8001, 32'h0,        1'b0, 1'b1, 32'h8001_A5EF};
      vecs[6]  = '{1'b0, 2'b01, 1'b1, 32'h0000_0012, 32'h0,         32'hFFFF_8001, 1'b0, 1'b0, 32'h0};
      vecs[7]  = '{1'b0, 2'b01, 1'b0, 32'h0000_0012, 32'h0,         32'h0000_8001, 1'b0, 1'b0, 32'h0};
      vecs[8]  = '{1'b0, 2'b10, 1'b0, 32'h0000_0013, 32'h0,         32'h0,        1'b1, 1'b0, 32'h0};
      vecs[9]  = '{1'b0, 2'b01, 1'b1, 32'h0000_0011, 32'h0,         32'h0,        1'b1, 1'b0, 32'h0};
      vecs[10] = '{1'b0, 2'b11, 1'b0, 32'h0000_0010, 32'h0,         32'h0,        1'b1, 1'b0, 32'h0};
      vecs[11] = '{1'b0, 2'b10, 1'b0, 32'h0000_0190, 32'h0,         32'h0,        1'b1, 1'b0, 32'h0};
      vecs[12] = '{1'b1, 2'b11, 1'b0, 32'h0000_0010, 32'h1234_5678, 32'h0,        1'b1, 1'b1, 32'h8001_A5EF};
      vecs[13] = '{1'b0, 2'b00, 1'b1, 32'h0000_0010, 32'h0,         32'hFFFF_FFEF, 1'b0, 1'b0, 32'h0};
      vecs[14] = '{1'b0, 2'b00, 1'b0, 32'h0000_0013, 32'h0,         32'h0000_0080, 1'b0, 1'b0, 32'h0};
      vecs[15] = '{1'b0, 2'b01, 1'b1, 32'h0000_0010, 32'h0,         32'hFFFF_A5EF, 1'b0, 1'b0, 32'h0};
      vecs[16] = '{1'b0, 2'b01, 1'b0, 32'h0000_0010, 32'h0,         32'h0000_A5EF, 1'b0, 1'b0, 32'h0};
      vecs[17] = '{1'b1, 2'b00, 1'b0, 32'h0000_018C, 32'hFFFF_FF7F, 32'h0,        1'b0, 1'b1, 32'h0000_007F};
      vecs[18] = '{1'b0, 2'b10, 1'b0, 32'h0000_018C, 32'h0,         32'h0000_007F, 1'b0, 1'b0, 32'h0};
      vecs[19] = '{1'b1, 2'b01, 1'b0, 32'h0000_0193, 32'h0000_ABCD, 32'h0,        1'b1, 1'b0, 32'h0};

      bb[0] = '{1'b0, 2'b10, 1'b0, 32'h0000_0010, 32'h0, 32'h8001_A5EF, 1'b0, 1'b0, 32'h0};
      bb[1] = '{1'b0, 2'b00, 1'b0, 32'h0000_0012, 32'h0, 32'h0000_0001, 1'b0, 1'b0, 32'h0};
      bb[2] = '{1'b0, 2'b10, 1'b0, 32'h0000_0190, 32'h0, 32'h0,         1'b1, 1'b0, 32'h0};
      bb[3] = '{1'b0, 2'b01, 1'b0, 32'h0000_0012, 32'h0, 32'h0000_8001, 1'b0, 1'b0, 32'h0};

      rst = 1'b0; req_valid = 1'b0; req_write = 1'b0; req_size = 2'b00;
      req_signed = 1'b0; req_addr = 32'h0; req_wdata = 32'h0;
      repeat (2) @(negedge clk);
      chk("reset_ready",     {31'd0, req_ready}, 32'd1);
      chk("reset_rsp_valid", {31'd0, rsp_valid}, 32'd0);
      chk("reset_rdata",     rsp_rdata, 32'h0);
      chk("reset_fault",     {31'd0, rsp_fault}, 32'd0);
      chk("reset_strobes",   {30'd0, mem_readmode, mem_writemode}, 32'd0);
      chk("reset_addr",      mem_address, 32'h0);
      chk("reset_dataIn",    mem_dataIn, 32'h0);
      rst = 1'b1;
      @(negedge clk);

      for (int i = 0; i < 20; i++) run_vec(i, vecs[i]);

      // Reset while a byte store sits in WRITE: memory must be left untouched
      while (!req_ready) @(negedge clk);
      req_write = 1'b1; req_size = 2'b00; req_signed = 1'b0;
      req_addr = 32'h0000_0020; req_wdata = 32'h0000_0055; req_valid = 1'b1;
      @(posedge clk);
      #1 req_valid = 1'b0;
      @(negedge clk);
      @(negedge clk);
      chk("rstw_in_write", {31'd0, mem_writemode}, 32'd1);
      rst = 1'b0;
      #1;
      chk("rstw_writemode", {31'd0, mem_writemode}, 32'd0);
      chk("rstw_ready",     {31'd0, req_ready}, 32'd1);
      chk("rstw_rsp_valid", {31'd0, rsp_valid}, 32'd0);
      chk("rstw_dataIn",    mem_dataIn, 32'h0);
      @(negedge clk);
      rst = 1'b1;
      saw_rsp = 1'b0;
      repeat (4) begin @(negedge clk); if (rsp_valid) saw_rsp = 1'b1; end
      chk("rstw_no_rsp", {31'd0, saw_rsp}, 32'd0);
      chk("rstw_mem",    tb_mem[8], 32'h0);

      // req_valid held high across four queued requests
      k = 0; got = 0; nacc = 0; acc_pend = 1'b0;
      drive(bb[0]);
      req_valid = 1'b1;
      for (int c = 0; c < 60 && got < 4; c++) begin
         if (acc_pend) begin
            k++;
            if (k < 4) drive(bb[k]);
            else req_valid = 1'b0;
            acc_pend = 1'b0;
         end
         if (rsp_valid) begin
            if (sb_q.size() == 0) begin
               chk("b2b_unexpected_rsp", 32'd1, 32'd0);
            end else begin
               e = sb_q.pop_front();
               chk($sformatf("b2b%0d_rdata", got), rsp_rdata, e.rdata);
               chk($sformatf("b2b%0d_fault", got), {31'd0, rsp_fault}, {31'd0, e.fault});
            end
            got++;
         end
         if (k < 4 && req_ready) begin
            sb_q.push_back('{rdata: bb[k].exp_rdata, fault: bb[k].exp_fault, lat: 0});
            acc_pend = 1'b1;
            nacc++;
         end
         @(negedge clk);
      end
      req_valid = 1'b0;
      chk("b2b_accepts",   nacc, 32'd4);
      chk("b2b_responses", got, 32'd4);

      $display("== %0d vectors applied, %0d miscompares ==", n_chk, n_fail);
      $finish;
   end

endmodule
